fpu_issue: RTL and testbench

FPU_ISSUE -- requirements
Module: fpu_issue

---
 rtl/fpu_pkg.sv | 43 ++++
 rtl/fpu_cmd_fifo.sv | 55 +++++
 rtl/fpu_issue.sv | 171 +++++++++++++++++
 tb/tb_fpu_issue.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU issue block: opcodes, flag bit positions,
// command word layout and the issue FSM state encoding.
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam int FLAG_INF_B = 0;
  localparam int FLAG_INF_A = 1;
  localparam int FLAG_NAN_B = 2;
  localparam int FLAG_NAN_A = 3;
  localparam int FLAG_S     = 4;
  localparam int FLAG_Z     = 5;
  localparam int FLAG_NOP   = 6;
  localparam int FLAGS_W    = 7;

  // A queued command carries the opcode and both operands.
  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } fpu_cmd_t;

  localparam int CMD_W = $bits(fpu_cmd_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_HOLD  = 2'b11
  } fpu_state_e;

  // Flags that may accumulate into the sticky register (the NOP marker never does).
  function automatic logic [FLAGS_W-1:0] sticky_mask();
    logic [FLAGS_W-1:0] m;
    m = {FLAGS_W{1'b1}};
    m[FLAG_NOP] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Command FIFO for the FPU issue block. Pointers carry one extra wrap bit so
// full and empty can be told apart by comparing the MSBs.
module fpu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = fpu_pkg::CMD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  // Advance write/read pointers on accepted push/pop; reset empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Store the incoming command at the tail slot.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/fpu_issue.sv
// FPU issue block: queues commands, presents one at a time to an external
// combinational FPU, captures its result and flags, and hands the result out
// on a valid/ready channel while accumulating sticky flags.
module fpu_issue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_a,
  input  logic [31:0]        in_b,
  input  logic [1:0]         in_op,
  output logic [31:0]        fpu_a,
  output logic [31:0]        fpu_b,
  output logic [1:0]         fpu_opcode,
  input  logic [31:0]        fpu_o,
  input  logic [FLAGS_W-1:0] fpu_flags,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_result,
  output logic [FLAGS_W-1:0] out_flags,
  output logic [FLAGS_W-1:0] sticky_flags,
  input  logic               sticky_clr,
  output logic               busy
);

  fpu_state_e         r_state;
  fpu_state_e         w_next_state;
  logic [31:0]        r_fpu_a;
  logic [31:0]        r_fpu_b;
  logic [1:0]         r_fpu_op;
  logic               r_out_valid;
  logic [31:0]        r_out_result;
  logic [FLAGS_W-1:0] r_out_flags;
  logic [FLAGS_W-1:0] r_sticky;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_capture;
  logic               w_release;
  fpu_cmd_t           w_wr_cmd;
  fpu_cmd_t           w_head;

  // in_ready depends only on the full flag, so a same-cycle pop never opens it.
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_wr_cmd = '{op: in_op, a: in_a, b: in_b};

  fpu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_wr_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode plus the pop/capture/release strobes.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = ST_ISSUE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        // A nop yields nothing: skip capture and return straight to IDLE.
        if (r_fpu_op == OP_NOP) begin
          w_next_state = ST_IDLE;
        end else begin
          w_capture    = 1'b1;
          w_next_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_release = 1'b1;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_next_state = ST_ISSUE;
          end else begin
            w_next_state = ST_IDLE;
          end
        end else begin
          w_next_state = ST_HOLD;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // FPU operand registers: loaded only when the FIFO head is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fpu_a  <= 32'h0000_0000;
      r_fpu_b  <= 32'h0000_0000;
      r_fpu_op <= OP_NOP;
    end else if (w_pop) begin
      r_fpu_a  <= w_head.a;
      r_fpu_b  <= w_head.b;
      r_fpu_op <= w_head.op;
    end
  end

  // Result channel: capture FPU output in WAIT, hold until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= 32'h0000_0000;
      r_out_flags  <= {FLAGS_W{1'b0}};
    end else if (w_capture) begin
      r_out_valid  <= 1'b1;
      r_out_result <= fpu_o;
      r_out_flags  <= fpu_flags;
    end else if (w_release) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Sticky flags: OR in captured flags; a clear on the same edge takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= {FLAGS_W{1'b0}};
    end else if (sticky_clr) begin
      r_sticky <= {FLAGS_W{1'b0}};
    end else if (w_capture) begin
      r_sticky <= r_sticky | (fpu_flags & sticky_mask());
    end
  end

  assign fpu_a        = r_fpu_a;
  assign fpu_b        = r_fpu_b;
  assign fpu_opcode   = r_fpu_op;
  assign out_valid    = r_out_valid;
  assign out_result   = r_out_result;
  assign out_flags    = r_out_flags;
  assign sticky_flags = r_sticky;
  assign busy         = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_fpu_issue.sv
// Scoreboard bench for fpu_issue with a small table-driven FPU model.
module tb_fpu_issue;
  import fpu_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_a;
  logic [31:0]        in_b;
  logic [1:0]         in_op;
  logic [31:0]        fpu_a;
  logic [31:0]        fpu_b;
  logic [1:0]         fpu_opcode;
  logic [31:0]        fpu_o;
  logic [FLAGS_W-1:0] fpu_flags = '0;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_result;
  logic [FLAGS_W-1:0] out_flags;
  logic [FLAGS_W-1:0] sticky_flags;
  logic               sticky_clr;
  logic               busy;

  typedef struct packed {
    logic [31:0]        res;
    logic [FLAGS_W-1:0] flg;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   hs_count = 0;

  fpu_issue #(.DEPTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_op        (in_op),
    .fpu_a        (fpu_a),
    .fpu_b        (fpu_b),
    .fpu_opcode   (fpu_opcode),
    .fpu_o        (fpu_o),
    .fpu_flags    (fpu_flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_flags    (out_flags),
    .sticky_flags (sticky_flags),
    .sticky_clr   (sticky_clr),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // FPU result model: hand-computed answers for the vectors used here.
  function automatic logic [31:0] fpu_model(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    case (op)
      OP_ADD: begin
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        else if (b == 32'h0000_0000) return a;
        else return 32'hDEAD_0000;
      end
      OP_SUB: begin
        if (a == b) return 32'h0000_0000;
        else return 32'hDEAD_0001;
      end
      OP_MUL: begin
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        else if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return 32'h7FC0_0000;
        else return 32'hDEAD_0002;
      end
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [FLAGS_W-1:0] flag_model(logic [31:0] a, logic [31:0] b, logic [1:0] op);
    logic [31:0]        r;
    logic [FLAGS_W-1:0] f;
    r = fpu_model(a, b, op);
    f = '0;
    f[FLAG_INF_B] = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    f[FLAG_INF_A] = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    f[FLAG_NAN_B] = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    f[FLAG_NAN_A] = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    f[FLAG_S]     = r[31];
    f[FLAG_Z]     = (r[30:0] == 31'd0);
    f[FLAG_NOP]   = (op == OP_NOP);
    return f;
  endfunction

  assign fpu_o = fpu_model(fpu_a, fpu_b, fpu_opcode);

  // The FPU registers its flags internally.
  always @(posedge clk) fpu_flags <= flag_model(fpu_a, fpu_b, fpu_opcode);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  // Monitor: every handshake must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", out_result, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_result", out_result, e.res);
        check("sb_flags", {25'd0, out_flags}, {25'd0, e.flg});
      end
      hs_count++;
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [31:0] er, input logic [FLAGS_W-1:0] ef);
    int n;
    n = 0;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      fail_now("send_wait");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    if (op != OP_NOP) sb_q.push_back('{res: er, flg: ef});
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin
      @(posedge clk); n++;
    end
    if (sb_q.size() != 0) fail_now("drain");
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_a [5] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000};
  int hs0;

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = OP_NOP;
    out_ready = 1'b1; sticky_clr = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fpu_opcode", {30'd0, fpu_opcode}, 32'd3);
    check("rst_fpu_a", fpu_a, 32'd0);
    check("rst_fpu_b", fpu_b, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", {25'd0, out_flags}, 32'd0);
    check("rst_sticky", {25'd0, sticky_flags}, 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Add with latency: valid must rise after the third edge past acceptance.
    send(32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h4040_0000, 7'h00);
    @(posedge clk); @(posedge clk); #1;
    check("lat_e2_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_e3_valid", {31'd0, out_valid}, 32'd1);
    check("add_result", out_result, 32'h4040_0000);
    check("add_flags_sz", {30'd0, out_flags[5:4]}, 32'd0);
    drain();
    check("sticky_after_add", {25'd0, sticky_flags}, 32'd0);

    // Sub to zero sets Z, which becomes sticky; a clear pulse removes it.
    send(32'h4040_0000, 32'h4040_0000, OP_SUB, 32'h0000_0000, 7'h20);
    drain();
    check("sticky_after_sub", {25'd0, sticky_flags}, 32'h20);
    sticky_clr = 1'b1;
    @(posedge clk); #1 sticky_clr = 1'b0;
    check("sticky_cleared", {25'd0, sticky_flags}, 32'd0);

    // Mul, then mul with a NaN A operand.
    send(32'h4000_0000, 32'h4040_0000, OP_MUL, 32'h40C0_0000, 7'h00);
    send(32'h7FC0_0000, 32'h4040_0000, OP_MUL, 32'h7FC0_0000, 7'h08);
    drain();
    check("sticky_after_nan", {25'd0, sticky_flags}, 32'h08);

    // Clear on the capture edge wins over accumulation.
    send(32'h4040_0000, 32'h4040_0000, OP_SUB, 32'h0000_0000, 7'h20);
    @(posedge clk); @(posedge clk); #1 sticky_clr = 1'b1;
    @(posedge clk); #1 sticky_clr = 1'b0;
    check("sticky_clr_vs_capture", {25'd0, sticky_flags}, 32'd0);
    drain();

    // Backpressure: five commands with the consumer stalled.
    out_ready = 1'b0;
    hs0 = hs_count;
    for (int i = 0; i < 5; i++) send(bp_a[i], 32'h0, OP_ADD, bp_a[i], 7'h00);
    check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("bp_in_ready_still_full", {31'd0, in_ready}, 32'd0);
    check("bp_no_handshake", hs_count - hs0, 32'd0);
    out_ready = 1'b1;
    drain();
    check("bp_handshakes", hs_count - hs0, 32'd5);
    check("bp_in_ready_free", {31'd0, in_ready}, 32'd1);

    // Nop interleave: exactly two results.
    hs0 = hs_count;
    send(32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h4040_0000, 7'h00);
    send(32'h1234_5678, 32'h9ABC_DEF0, OP_NOP, 32'h0, 7'h00);
    send(32'h4000_0000, 32'h4040_0000, OP_MUL, 32'h40C0_0000, 7'h00);
    drain();
    repeat (10) @(posedge clk);
    #1;
    check("nop_handshakes", hs_count - hs0, 32'd2);

    // Reset while in WAIT with three commands queued behind.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(bp_a[i], 32'h0, OP_ADD, bp_a[i], 7'h00);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_fpu_opcode", {30'd0, fpu_opcode}, 32'd3);
    sb_q.delete();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    hs0 = hs_count;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_no_output", hs_count - hs0, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // First command after reset keeps the same latency.
    send(32'h3F80_0000, 32'h4000_0000, OP_ADD, 32'h4040_0000, 7'h00);
    @(posedge clk); @(posedge clk); #1;
    check("lat2_e2_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat2_e3_valid", {31'd0, out_valid}, 32'd1);
    drain();
    check("final_handshakes", hs_count - hs0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
